// File: rtl/block_sync_ctrl.sv
// 66b block-sync control FSM: HOLDOFF -> SEARCH -> CONFIRM -> LOCKED with windowed loss detection.
// Optional lock statistics outputs are enabled by defining BLOCK_SYNC_STATS_EN.
module block_sync_ctrl #(
  parameter int unsigned HOLD_N    = 16,
  parameter int unsigned CONFIRM_N = 32,
  parameter int unsigned WIN_N     = 64,
  parameter int unsigned BAD_MAX   = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cand_dv_i,
  input  logic [6:0] cand_offset_i,
  input  logic       hdr_dv_i,
  input  logic [1:0] hdr_i,
  input  logic       restart_i,
  output logic [6:0] offset_o,
  output logic       offset_ld_o,
  output logic       locked_o,
  output logic [1:0] state_o
`ifdef BLOCK_SYNC_STATS_EN
  ,
  output logic [7:0] lock_loss_cnt_o,
  output logic [7:0] relock_cnt_o
`endif
);

  localparam int unsigned HoldW = $clog2(HOLD_N + 1);
  localparam int unsigned GoodW = $clog2(CONFIRM_N + 1);
  localparam int unsigned WinW  = $clog2(WIN_N + 1);
  localparam int unsigned BadW  = $clog2(BAD_MAX + 1);

  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_N - 1);
  localparam logic [GoodW-1:0] GoodLast = GoodW'(CONFIRM_N - 1);
  localparam logic [WinW-1:0]  WinLast  = WinW'(WIN_N - 1);
  localparam logic [BadW-1:0]  BadLimit = BadW'(BAD_MAX);
  localparam logic [6:0]       MaxOffset = 7'd65;

  typedef enum logic [1:0] {
    StHoldoff = 2'b00,
    StSearch  = 2'b01,
    StConfirm = 2'b10,
    StLocked  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       offset_q, offset_d;
  logic             ld_q, ld_d;
  logic             locked_q, locked_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [GoodW-1:0] good_q, good_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [BadW-1:0]  bad_q, bad_d, bad_nxt;
  logic             hdr_ok;

  // 01 (data) and 10 (command) are the only legal sync headers.
  assign hdr_ok  = hdr_i[1] ^ hdr_i[0];
  assign bad_nxt = bad_q + BadW'(!hdr_ok);

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    ld_d     = 1'b0;
    hold_d   = hold_q;
    good_d   = good_q;
    win_d    = win_q;
    bad_d    = bad_q;

    if (restart_i) begin
      state_d = StHoldoff;
      hold_d  = '0;
      good_d  = '0;
      win_d   = '0;
      bad_d   = '0;
    end else begin
      unique case (state_q)
        StHoldoff: begin
          if (cand_dv_i) begin
            if (hold_q == HoldLast) begin
              state_d = StSearch;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        StSearch: begin
          if (cand_dv_i && (cand_offset_i <= MaxOffset)) begin
            state_d  = StConfirm;
            offset_d = cand_offset_i;
            ld_d     = 1'b1;
            good_d   = '0;
          end
        end
        StConfirm: begin
          if (hdr_dv_i) begin
            if (!hdr_ok) begin
              state_d = StHoldoff;
              good_d  = '0;
            end else if (good_q == GoodLast) begin
              state_d = StLocked;
              good_d  = '0;
              win_d   = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end
        end
        StLocked: begin
          if (hdr_dv_i) begin
            // Loss of lock wins over the window rollover on the final sample.
            if (bad_nxt == BadLimit) begin
              state_d = StHoldoff;
              win_d   = '0;
              bad_d   = '0;
            end else if (win_q == WinLast) begin
              win_d = '0;
              bad_d = '0;
            end else begin
              win_d = win_q + 1'b1;
              bad_d = bad_nxt;
            end
          end
        end
      endcase
    end

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StHoldoff;
      offset_q <= '0;
      ld_q     <= 1'b0;
      locked_q <= 1'b0;
      hold_q   <= '0;
      good_q   <= '0;
      win_q    <= '0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      ld_q     <= ld_d;
      locked_q <= locked_d;
      hold_q   <= hold_d;
      good_q   <= good_d;
      win_q    <= win_d;
      bad_q    <= bad_d;
    end
  end

  assign offset_o    = offset_q;
  assign offset_ld_o = ld_q;
  assign locked_o    = locked_q;
  assign state_o     = state_q;

`ifdef BLOCK_SYNC_STATS_EN
  logic [7:0] loss_q, relock_q;
  logic       locked_once_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loss_q        <= '0;
      relock_q      <= '0;
      locked_once_q <= 1'b0;
    end else begin
      if (state_q == StLocked && state_d == StHoldoff && loss_q != 8'hFF) begin
        loss_q <= loss_q + 1'b1;
      end
      if (state_q == StConfirm && state_d == StLocked) begin
        locked_once_q <= 1'b1;
        if (locked_once_q && relock_q != 8'hFF) begin
          relock_q <= relock_q + 1'b1;
        end
      end
    end
  end

  assign lock_loss_cnt_o = loss_q;
  assign relock_cnt_o    = relock_q;
`endif

endmodule

// File: tb/tb_block_sync_ctrl.sv
// Self-checking bench for block_sync_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_block_sync_ctrl;
  localparam int HOLD_N = 16, CONFIRM_N = 32, WIN_N = 64, BAD_MAX = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       cand_dv_i = 1'b0;
  logic [6:0] cand_offset_i = '0;
  logic       hdr_dv_i = 1'b0;
  logic [1:0] hdr_i = 2'b01;
  logic       restart_i = 1'b0;
  logic [6:0] offset_o;
  logic       offset_ld_o, locked_o;
  logic [1:0] state_o;
`ifdef BLOCK_SYNC_STATS_EN
  logic [7:0] lock_loss_cnt_o, relock_cnt_o;
`endif

  block_sync_ctrl #(
    .HOLD_N(HOLD_N), .CONFIRM_N(CONFIRM_N), .WIN_N(WIN_N), .BAD_MAX(BAD_MAX)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cand_dv_i(cand_dv_i), .cand_offset_i(cand_offset_i),
    .hdr_dv_i(hdr_dv_i), .hdr_i(hdr_i), .restart_i(restart_i), .offset_o(offset_o),
    .offset_ld_o(offset_ld_o), .locked_o(locked_o), .state_o(state_o)
`ifdef BLOCK_SYNC_STATS_EN
    , .lock_loss_cnt_o(lock_loss_cnt_o), .relock_cnt_o(relock_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: pulse count, header streak, and a list of the current window's verdicts.
  int m_state = 0, m_off = 0, m_ld = 0, m_locked = 0, m_hold = 0, m_streak = 0;
  int m_loss = 0;
  bit win_hist[$];

  function automatic void model_reset();
    m_state = 0; m_off = 0; m_ld = 0; m_locked = 0; m_hold = 0; m_streak = 0;
    win_hist.delete();
  endfunction

  function automatic void model_step(input bit cdv, input int off, input bit hdv, input int hdr,
                                     input bit rst);
    bit ok;
    int nbad;
    ok = (hdr == 1) || (hdr == 2);
    m_ld = 0;
    if (rst) begin
      if (m_state == 3) m_loss++;
      m_state = 0; m_hold = 0; m_streak = 0; win_hist.delete();
    end else begin
      case (m_state)
        0: if (cdv) begin
          m_hold++;
          if (m_hold == HOLD_N) begin m_state = 1; m_hold = 0; end
        end
        1: if (cdv && off <= 65) begin
          m_off = off; m_ld = 1; m_streak = 0; m_state = 2;
        end
        2: if (hdv) begin
          if (!ok) begin m_state = 0; m_streak = 0; end
          else begin
            m_streak++;
            if (m_streak == CONFIRM_N) begin m_state = 3; m_streak = 0; win_hist.delete(); end
          end
        end
        default: if (hdv) begin
          win_hist.push_back(ok);
          nbad = 0;
          foreach (win_hist[i]) if (!win_hist[i]) nbad++;
          if (nbad == BAD_MAX) begin m_state = 0; m_loss++; win_hist.delete(); end
          else if (win_hist.size() == WIN_N) win_hist.delete();
        end
      endcase
    end
    m_locked = (m_state == 3);
  endfunction

  int ld_seen = 0;

  task automatic cyc(input bit cdv, input int off, input bit hdv, input int hdr, input bit rst);
    cand_dv_i = cdv; cand_offset_i = 7'(off); hdr_dv_i = hdv; hdr_i = 2'(hdr); restart_i = rst;
    @(posedge clk_i);
    model_step(cdv, off, hdv, hdr, rst);
    #1;
    ld_seen += int'(offset_ld_o);
    check_eq("state", int'(state_o), m_state);
    check_eq("offset", int'(offset_o), m_off);
    check_eq("offset_ld", int'(offset_ld_o), m_ld);
    check_eq("locked", int'(locked_o), m_locked);
  endtask

  task automatic pulses(input int n, input int off);
    for (int i = 0; i < n; i++) cyc(1'b1, off, 1'b0, 1, 1'b0);
  endtask

  task automatic hdrs(input int n, input int hdr);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b1, hdr, 1'b0);
  endtask

  // One window of WIN_N samples with nbad invalid headers spread through it.
  task automatic window(input int nbad);
    for (int i = 0; i < WIN_N; i++) cyc(1'b0, 0, 1'b1, (i % 8 == 3 && i / 8 < nbad) ? 3 : 2, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, int'(state_o), 0);
    check_eq({tag, "_offset"}, int'(offset_o), 0);
    check_eq({tag, "_ld"}, int'(offset_ld_o), 0);
    check_eq({tag, "_locked"}, int'(locked_o), 0);
  endtask

  initial begin
    int err_pct, hdr;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    model_reset();

    // Acquire at offset 23: 16 holdoff pulses, one load, 32 good headers.
    ld_seen = 0;
    pulses(HOLD_N + 1, 23);
    hdrs(CONFIRM_N - 1, 1);
    check_eq("no_early_lock", int'(locked_o), 0);
    hdrs(1, 2);
    check_eq("ld_single_pulse", ld_seen, 1);
    check_eq("acq_offset", int'(offset_o), 23);
    check_eq("acq_locked", int'(locked_o), 1);
    check_eq("acq_state", int'(state_o), 3);

    // 7 bad per window twice keeps lock; 8 in one window drops it.
    window(BAD_MAX - 1);
    window(BAD_MAX - 1);
    check_eq("win_keep_lock", int'(locked_o), 1);
    window(BAD_MAX);
    check_eq("win_lost_state", int'(state_o), 0);
`ifdef BLOCK_SYNC_STATS_EN
    check_eq("lock_loss_cnt", int'(lock_loss_cnt_o), 1);
`endif

    // Invalid header partway through CONFIRM.
    pulses(HOLD_N + 1, 23);
    hdrs(10, 1);
    hdrs(1, 3);
    check_eq("confirm_fail_state", int'(state_o), 0);
    check_eq("confirm_fail_locked", int'(locked_o), 0);
    check_eq("confirm_fail_offset", int'(offset_o), 23);

    // Out-of-range candidate ignored, then a legal one loads.
    pulses(HOLD_N, 23);
    cyc(1'b1, 70, 1'b0, 1, 1'b0);
    check_eq("off70_state", int'(state_o), 1);
    check_eq("off70_no_ld", int'(offset_ld_o), 0);
    cyc(1'b1, 5, 1'b0, 1, 1'b0);
    check_eq("off5_offset", int'(offset_o), 5);
    check_eq("off5_state", int'(state_o), 2);

    // Restart together with a header sample while locked.
    hdrs(CONFIRM_N, 1);
    check_eq("relock", int'(locked_o), 1);
    cyc(1'b0, 0, 1'b1, 1, 1'b1);
    check_eq("restart_state", int'(state_o), 0);
    check_eq("restart_locked", int'(locked_o), 0);
    check_eq("restart_offset", int'(offset_o), 5);

    // Asynchronous reset while locked.
    pulses(HOLD_N + 1, 40);
    hdrs(CONFIRM_N, 2);
    check_eq("pre_areset_locked", int'(locked_o), 1);
    cyc(1'b0, 0, 1'b0, 1, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check_reset_outputs("areset_async");
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("areset_held");
    rst_ni = 1'b1;
    model_reset();

    // Randomized traffic with varying header error rates.
    for (int ph = 0; ph < 30; ph++) begin
      case ($urandom_range(0, 3))
        0: err_pct = 0;
        1: err_pct = 1;
        2: err_pct = 5;
        default: err_pct = 30;
      endcase
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 99) < err_pct) hdr = ($urandom_range(0, 1) != 0) ? 3 : 0;
        else hdr = ($urandom_range(0, 1) != 0) ? 2 : 1;
        cyc($urandom_range(0, 1) != 0, $urandom_range(0, 80), $urandom_range(0, 3) != 0, hdr,
            $urandom_range(0, 299) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
